// File: rtl/varredura_pkg.sv
// Shared definitions for the two-digit multiplexed 7-segment scanner.
package varredura_pkg;

    // Scan FSM: units window, guard, tens window, guard
    typedef enum logic [1:0] {
        UNI      = 2'd0,
        GUARDA_U = 2'd1,
        DEZ      = 2'd2,
        GUARDA_D = 2'd3
    } estado_t;

    // Active-low segment patterns, bit6=g ... bit0=a
    localparam logic [6:0] SEG_APAGADO = 7'b1111111;
    localparam logic [6:0] SEG_TRACO   = 7'b0111111;
    localparam logic [6:0] SEG_0       = 7'b1000000;
    localparam logic [6:0] SEG_1       = 7'b1111001;
    localparam logic [6:0] SEG_2       = 7'b0100100;
    localparam logic [6:0] SEG_3       = 7'b0110000;
    localparam logic [6:0] SEG_4       = 7'b0011001;
    localparam logic [6:0] SEG_5       = 7'b0010010;
    localparam logic [6:0] SEG_6       = 7'b0000010;
    localparam logic [6:0] SEG_7       = 7'b1111000;
    localparam logic [6:0] SEG_8       = 7'b0000000;
    localparam logic [6:0] SEG_9       = 7'b0010000;

endpackage

// File: rtl/varredura_display_if.sv
// Digit inputs, display controls and display pins of the scanner.
interface varredura_display_if;
    logic [3:0] Dezenas;
    logic [3:0] Unidades;
    logic       Carregar;
    logic       Piscar;
    logic       ApagarZero;
    logic [6:0] Segmentos;
    logic [1:0] Anodos;
    logic       Erro;

    // Driver of digits/controls (converter side, or the bench)
    modport master (
        output Dezenas, Unidades, Carregar, Piscar, ApagarZero,
        input  Segmentos, Anodos, Erro
    );

    // The scanner itself
    modport slave (
        input  Dezenas, Unidades, Carregar, Piscar, ApagarZero,
        output Segmentos, Anodos, Erro
    );
endinterface

// File: rtl/varredura_display_decodificador7seg.sv
// BCD to active-low 7-segment decoder; codes above 9 show a dash.
module decodificador7seg
    import varredura_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_c
);

    // Pure lookup, no state
    always_comb begin
        o_seg_c = SEG_TRACO;
        case (i_bcd)
            4'd0:    o_seg_c = SEG_0;
            4'd1:    o_seg_c = SEG_1;
            4'd2:    o_seg_c = SEG_2;
            4'd3:    o_seg_c = SEG_3;
            4'd4:    o_seg_c = SEG_4;
            4'd5:    o_seg_c = SEG_5;
            4'd6:    o_seg_c = SEG_6;
            4'd7:    o_seg_c = SEG_7;
            4'd8:    o_seg_c = SEG_8;
            4'd9:    o_seg_c = SEG_9;
            default: o_seg_c = SEG_TRACO;
        endcase
    end

endmodule

// File: rtl/varredura_display.sv
// Two-digit multiplexed display scanner with guard cycles, blanking and blink.
module varredura_display
    import varredura_pkg::*;
#(
    parameter int unsigned DIVISOR    = 50000,
    parameter int unsigned BLINK_HALF = 250
) (
    input  logic                 Clock,
    input  logic                 Reset,
    varredura_display_if.slave   bus
);

    localparam int unsigned PRE_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam int unsigned BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIVISOR - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_HALF - 1);

    estado_t            r_estado;
    estado_t            w_proximo;
    logic [PRE_W-1:0]   r_pre;
    logic [BLK_W-1:0]   r_blk;
    logic               r_fase;
    logic [3:0]         r_dez;
    logic [3:0]         r_uni;
    logic               r_erro;
    logic [6:0]         r_seg;
    logic [1:0]         r_anodos;

    logic               w_fim_janela;
    logic [1:0]         w_anodos;
    logic [3:0]         w_digito;
    logic [6:0]         w_seg_dec;
    logic [6:0]         w_seg;

    assign w_fim_janela = (r_pre == PRE_MAX);

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_estado <= UNI;
        else       r_estado <= w_proximo;
    end

    // Next state and digit enables for the current window
    always_comb begin
        w_proximo = r_estado;
        w_anodos  = 2'b11;
        case (r_estado)
            UNI: begin
                w_anodos = 2'b10;
                if (w_fim_janela) w_proximo = GUARDA_U;
            end
            GUARDA_U: w_proximo = DEZ;
            DEZ: begin
                if (!(bus.ApagarZero && (r_dez == 4'd0))) w_anodos = 2'b01;
                if (w_fim_janela) w_proximo = GUARDA_D;
            end
            GUARDA_D: w_proximo = UNI;
            default:  w_proximo = UNI;
        endcase
        if (!r_fase) w_anodos = 2'b11;
    end

    // Digit select, decode, and force dark whenever no digit is enabled
    assign w_digito = (r_estado == DEZ) ? r_dez : r_uni;

    decodificador7seg u_decod (
        .i_bcd   (w_digito),
        .o_seg_c (w_seg_dec)
    );

    assign w_seg = (w_anodos == 2'b11) ? SEG_APAGADO : w_seg_dec;

    // Window prescaler: runs inside UNI/DEZ, restarts on every state change
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_pre <= '0;
        end else if (w_proximo != r_estado) begin
            r_pre <= '0;
        end else if ((r_estado == UNI) || (r_estado == DEZ)) begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Blink counter: one step per completed scan, phase flips every BLINK_HALF scans
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_blk  <= '0;
            r_fase <= 1'b1;
        end else if (!bus.Piscar) begin
            r_blk  <= '0;
            r_fase <= 1'b1;
        end else if (r_estado == GUARDA_D) begin
            if (r_blk == BLK_MAX) begin
                r_blk  <= '0;
                r_fase <= ~r_fase;
            end else begin
                r_blk  <= r_blk + BLK_W'(1);
            end
        end
    end

    // Digit capture and invalid-digit flag
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_dez  <= 4'd0;
            r_uni  <= 4'd0;
            r_erro <= 1'b0;
        end else if (bus.Carregar) begin
            r_dez  <= bus.Dezenas;
            r_uni  <= bus.Unidades;
            r_erro <= (bus.Dezenas > 4'd9) || (bus.Unidades > 4'd9);
        end
    end

    // Registered display pins
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_seg    <= SEG_APAGADO;
            r_anodos <= 2'b11;
        end else begin
            r_seg    <= w_seg;
            r_anodos <= w_anodos;
        end
    end

    assign bus.Segmentos = r_seg;
    assign bus.Anodos    = r_anodos;
    assign bus.Erro      = r_erro;

endmodule
